// File: rtl/level_sequencer_pkg.sv
// Shared definitions for the level sequencer: field widths, default
// round parameters, FSM state encoding and a saturating level helper.
// SEQ_LIVES_EN selects multi-life play; without it the first miss ends the game.
package level_sequencer_pkg;

  localparam int LEVEL_W         = 4;
  localparam int SEC_W           = 4;
  localparam int DEF_MAX_LEVEL   = 9;
  localparam int DEF_PLAY_TIME_S = 5;
  localparam int DEF_LIVES       = 3;

`ifdef SEQ_LIVES_EN
  localparam bit LIVES_EN = 1'b1;
`else
  localparam bit LIVES_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_COUNTDOWN = 3'd2,
    ST_PLAY      = 3'd3,
    ST_CHECK     = 3'd4,
    ST_WIN       = 3'd5,
    ST_LOSE      = 3'd6
  } seq_state_e;

  // Next level, pinned at the top level so the counter can never wrap.
  function automatic logic [LEVEL_W-1:0] level_inc(input logic [LEVEL_W-1:0] lvl,
                                                   input logic [LEVEL_W-1:0] top);
    return (lvl >= top) ? top : lvl + LEVEL_W'(1);
  endfunction

endpackage

// File: rtl/level_sequencer_round.sv
// round_timer: seconds counter for the player input window. Loaded with the
// window length, stepped down by the 1 Hz strobe while running, and flags a
// timeout on the strobe that would take it from 1 to 0.
module round_timer
  import level_sequencer_pkg::*;
#(
  parameter int PLAY_TIME_S = DEF_PLAY_TIME_S
) (
  input  logic             Clk100M,
  input  logic             Reset_n,
  input  logic             load,
  input  logic             run,
  input  logic             tick1Hz,
  output logic [SEC_W-1:0] secLeft,
  output logic             timeout
);

  localparam logic [SEC_W-1:0] SEC_LOAD = SEC_W'(PLAY_TIME_S);

  logic step;

  assign step    = run && tick1Hz && (secLeft != '0);
  // Combinational so the FSM leaves PLAY on the very edge the count hits zero.
  assign timeout = step && (secLeft == SEC_W'(1));

  // Loadable down-counter, enabled by the 1 Hz strobe.
  always_ff @(posedge Clk100M or negedge Reset_n) begin
    if (!Reset_n) begin
      secLeft <= '0;
    end else if (load) begin
      secLeft <= SEC_LOAD;
    end else if (step) begin
      secLeft <= secLeft - SEC_W'(1);
    end
  end

endmodule

// File: rtl/level_sequencer.sv
// level_sequencer: round sequencing for the countdown/level game.
// Optional multi-life play is enabled with SEQ_LIVES_EN.
//
// state        | meaning
// -------------+---------------------------------------------------
// ST_IDLE      | waiting for the first start request
// ST_ARM       | one-cycle start pulse to the countdown timer
// ST_COUNTDOWN | waiting for the countdown timer's done pulse
// ST_PLAY      | input window open, seconds counting down
// ST_CHECK     | judge the answer; advance, retry or end
// ST_WIN       | game won, win held until the next start
// ST_LOSE      | game lost, gameOver held until the next start
module level_sequencer
  import level_sequencer_pkg::*;
#(
  parameter int MAX_LEVEL   = DEF_MAX_LEVEL,
  parameter int PLAY_TIME_S = DEF_PLAY_TIME_S,
  parameter int LIVES       = DEF_LIVES
) (
  input  logic               Clk100M,
  input  logic               Reset_n,
  input  logic               tick1Hz,
  input  logic               startBtn,
  input  logic               timerDone,
  input  logic               playerSubmit,
  input  logic               playerCorrect,
  output logic               timerStart,
  output logic [LEVEL_W-1:0] curLevel,
  output logic               inputEnable,
  output logic [SEC_W-1:0]   secLeft,
  output logic [1:0]         livesLeft,
  output logic               win,
  output logic               gameOver
);

  localparam logic [LEVEL_W-1:0] LEVEL_MAX   = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0] LEVEL_FIRST = LEVEL_W'(1);
  // Without the multi-life option the life count is pinned at one.
  localparam logic [1:0]         LIVES_INIT  = LIVES_EN ? 2'(LIVES) : 2'd1;

  seq_state_e state_q, state_d;
  logic       verdict_q;
  logic       timeout;
  logic       restart;
  logic       timer_load;
  logic       timer_run;
  logic       timer_start_d, input_enable_d, win_d, game_over_d;

  assign restart    = startBtn && ((state_q == ST_IDLE) || (state_q == ST_WIN) ||
                                   (state_q == ST_LOSE));
  assign timer_load = (state_q == ST_COUNTDOWN) && timerDone;
  // A submit in the same cycle as a tick takes priority; the tick is dropped.
  assign timer_run  = (state_q == ST_PLAY) && !playerSubmit;

  round_timer #(
    .PLAY_TIME_S (PLAY_TIME_S)
  ) u_round_timer (
    .Clk100M (Clk100M),
    .Reset_n (Reset_n),
    .load    (timer_load),
    .run     (timer_run),
    .tick1Hz (tick1Hz),
    .secLeft (secLeft),
    .timeout (timeout)
  );

  // State register.
  always_ff @(posedge Clk100M or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (startBtn) state_d = ST_ARM;
      ST_ARM:       state_d = ST_COUNTDOWN;
      ST_COUNTDOWN: if (timerDone) state_d = ST_PLAY;
      ST_PLAY:      if (playerSubmit || timeout) state_d = ST_CHECK;
      ST_CHECK: begin
        if (verdict_q) begin
          state_d = (curLevel >= LEVEL_MAX) ? ST_WIN : ST_ARM;
        end else begin
`ifdef SEQ_LIVES_EN
          state_d = (livesLeft > 2'd1) ? ST_ARM : ST_LOSE;
`else
          state_d = ST_LOSE;
`endif
        end
      end
      ST_WIN:       if (startBtn) state_d = ST_ARM;
      ST_LOSE:      if (startBtn) state_d = ST_ARM;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs line up with the state.
  always_comb begin
    timer_start_d  = (state_d == ST_ARM);
    input_enable_d = (state_d == ST_PLAY);
    win_d          = (state_d == ST_WIN);
    game_over_d    = (state_d == ST_LOSE);
  end

  // Registered control outputs.
  always_ff @(posedge Clk100M or negedge Reset_n) begin
    if (!Reset_n) begin
      timerStart  <= 1'b0;
      inputEnable <= 1'b0;
      win         <= 1'b0;
      gameOver    <= 1'b0;
    end else begin
      timerStart  <= timer_start_d;
      inputEnable <= input_enable_d;
      win         <= win_d;
      gameOver    <= game_over_d;
    end
  end

  // Verdict latch: the answer on submit, a miss on timeout.
  always_ff @(posedge Clk100M or negedge Reset_n) begin
    if (!Reset_n) begin
      verdict_q <= 1'b0;
    end else if (state_q == ST_PLAY) begin
      if (playerSubmit) begin
        verdict_q <= playerCorrect;
      end else if (timeout) begin
        verdict_q <= 1'b0;
      end
    end
  end

  // Level and life bookkeeping, reloaded on every (re)start.
  always_ff @(posedge Clk100M or negedge Reset_n) begin
    if (!Reset_n) begin
      curLevel  <= LEVEL_FIRST;
      livesLeft <= LIVES_INIT;
    end else if (restart) begin
      curLevel  <= LEVEL_FIRST;
      livesLeft <= LIVES_INIT;
    end else if (state_q == ST_CHECK) begin
      if (verdict_q) begin
        curLevel <= level_inc(curLevel, LEVEL_MAX);
      end
`ifdef SEQ_LIVES_EN
      else if (livesLeft != 2'd0) begin
        livesLeft <= livesLeft - 2'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_level_sequencer.sv
// Scoreboard bench for level_sequencer: a small game model pushes the
// expected round outcome when an answer or timeout is driven, and the
// entry is popped and compared when the DUT signals the outcome.
module tb_level_sequencer;

  localparam int PT   = 5;
  localparam int MAXL = 9;
`ifdef SEQ_LIVES_EN
  localparam int LIVES_EXP = 3;
`else
  localparam int LIVES_EXP = 1;
`endif

  logic       Clk100M;
  logic       Reset_n;
  logic       tick1Hz, startBtn, timerDone, playerSubmit, playerCorrect;
  logic       timerStart, inputEnable, win, gameOver;
  logic [3:0] curLevel, secLeft;
  logic [1:0] livesLeft;

  typedef struct {
    logic [3:0] level;
    logic [1:0] lives;
    logic       won;
    logic       over;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   m_level, m_lives;
  bit   m_win, m_over;

  level_sequencer dut (
    .Clk100M       (Clk100M),
    .Reset_n       (Reset_n),
    .tick1Hz       (tick1Hz),
    .startBtn      (startBtn),
    .timerDone     (timerDone),
    .playerSubmit  (playerSubmit),
    .playerCorrect (playerCorrect),
    .timerStart    (timerStart),
    .curLevel      (curLevel),
    .inputEnable   (inputEnable),
    .secLeft       (secLeft),
    .livesLeft     (livesLeft),
    .win           (win),
    .gameOver      (gameOver)
  );

  initial Clk100M = 1'b0;
  always #5 Clk100M = ~Clk100M;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk100M);
    #1;
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_timerStart"}, timerStart, 0);
    chk({pfx, "_inputEnable"}, inputEnable, 0);
    chk({pfx, "_curLevel"}, curLevel, 1);
    chk({pfx, "_livesLeft"}, livesLeft, LIVES_EXP);
    chk({pfx, "_secLeft"}, secLeft, 0);
    chk({pfx, "_win"}, win, 0);
    chk({pfx, "_gameOver"}, gameOver, 0);
  endtask

  task automatic start_game();
    startBtn = 1'b1;
    cyc();
    startBtn = 1'b0;
    m_level = 1; m_lives = LIVES_EXP; m_win = 1'b0; m_over = 1'b0;
    chk("start_timerStart", timerStart, 1);
    chk("start_curLevel", curLevel, 1);
    chk("start_livesLeft", livesLeft, LIVES_EXP);
    chk("start_win_clear", win, 0);
    chk("start_gameOver_clear", gameOver, 0);
  endtask

  // Update the model for one judged round and queue the expected outcome.
  task automatic model_round(input bit correct);
    exp_t e;
    if (correct) begin
      if (m_level == MAXL) m_win = 1'b1;
      else m_level++;
    end else begin
`ifdef SEQ_LIVES_EN
      if (m_lives > 1) m_lives--;
      else begin m_lives = 0; m_over = 1'b1; end
`else
      m_over = 1'b1;
`endif
    end
    e.level = 4'(m_level);
    e.lives = 2'(m_lives);
    e.won   = m_win;
    e.over  = m_over;
    sb.push_back(e);
  endtask

  // mode: 0 correct submit, 1 wrong submit, 2 timeout, 3 correct submit on the timeout tick.
  // Entered in the ARM cycle; returns in the cycle the outcome is visible.
  task automatic play_round(input int mode);
    exp_t e;
    int   waited;
    bit   correct;
    correct = (mode == 0) || (mode == 3);
    cyc();
    chk("timerStart_one_cycle", timerStart, 0);
    startBtn = 1'b1; tick1Hz = 1'b1;
    cyc();
    startBtn = 1'b0; tick1Hz = 1'b0;
    chk("start_ignored_countdown", timerStart, 0);
    chk("closed_in_countdown", inputEnable, 0);
    timerDone = 1'b1;
    cyc();
    timerDone = 1'b0;
    chk("window_open", inputEnable, 1);
    chk("sec_loaded", secLeft, PT);
    if (mode == 2) begin
      for (int i = 0; i < PT; i++) begin
        chk("sec_step", secLeft, PT - i);
        tick1Hz = 1'b1;
        cyc();
        tick1Hz = 1'b0;
        if (i < PT - 1) cyc();
      end
      chk("sec_timeout_zero", secLeft, 0);
    end else if (mode == 3) begin
      for (int i = 0; i < PT - 1; i++) begin
        tick1Hz = 1'b1;
        cyc();
        tick1Hz = 1'b0;
      end
      chk("sec_at_one", secLeft, 1);
      tick1Hz = 1'b1; playerSubmit = 1'b1; playerCorrect = 1'b1;
      cyc();
      tick1Hz = 1'b0; playerSubmit = 1'b0; playerCorrect = 1'b0;
      chk("tick_discarded", secLeft, 1);
    end else begin
      playerSubmit = 1'b1; playerCorrect = correct;
      cyc();
      playerSubmit = 1'b0; playerCorrect = 1'b0;
    end
    chk("window_closed", inputEnable, 0);
    model_round(correct);
    waited = 0;
    while (1) begin
      cyc();
      waited++;
      if (timerStart || win || gameOver || waited >= 8) break;
    end
    chk("outcome_seen", {31'd0, timerStart | win | gameOver}, 1);
    e = sb.pop_front();
    chk("outcome_latency", waited, 1);
    chk("outcome_curLevel", curLevel, e.level);
    chk("outcome_livesLeft", livesLeft, e.lives);
    chk("outcome_win", win, e.won);
    chk("outcome_gameOver", gameOver, e.over);
    chk("outcome_timerStart", timerStart, !(e.won || e.over));
  endtask

  initial begin
    Reset_n = 1'b0;
    tick1Hz = 1'b0; startBtn = 1'b0; timerDone = 1'b0;
    playerSubmit = 1'b0; playerCorrect = 1'b0;
    repeat (3) cyc();
    check_reset("rst");
    Reset_n = 1'b1;
    cyc();

    // Stray strobes in IDLE do nothing.
    timerDone = 1'b1; playerSubmit = 1'b1; playerCorrect = 1'b1; tick1Hz = 1'b1;
    cyc();
    timerDone = 1'b0; playerSubmit = 1'b0; playerCorrect = 1'b0; tick1Hz = 1'b0;
    cyc();
    chk("idle_stray_timerStart", timerStart, 0);
    chk("idle_stray_inputEnable", inputEnable, 0);
    chk("idle_stray_curLevel", curLevel, 1);

    start_game();
    play_round(0);
    play_round(3);
    play_round(2);
    while (!m_over) begin
      play_round(1);
      if (!m_over) play_round(2);
    end

    // Loss is sticky; stray strobes leave it alone.
    repeat (4) begin
      timerDone = 1'b1; playerSubmit = 1'b1; playerCorrect = 1'b1;
      cyc();
      timerDone = 1'b0; playerSubmit = 1'b0; playerCorrect = 1'b0;
    end
    chk("lose_held", gameOver, 1);
    chk("lose_level_held", curLevel, m_level);
    chk("lose_no_win", win, 0);
    chk("lose_no_timerStart", timerStart, 0);

    start_game();
    for (int r = 0; r < MAXL; r++) play_round(0);

    // Win is sticky at the top level; a further submit is ignored.
    playerSubmit = 1'b1; playerCorrect = 1'b1;
    cyc();
    playerSubmit = 1'b0; playerCorrect = 1'b0;
    repeat (3) cyc();
    chk("win_held", win, 1);
    chk("win_level_max", curLevel, MAXL);
    chk("win_window_closed", inputEnable, 0);
    chk("win_no_timerStart", timerStart, 0);

    start_game();

    // Reset in the middle of PLAY.
    cyc();
    timerDone = 1'b1;
    cyc();
    timerDone = 1'b0;
    tick1Hz = 1'b1;
    cyc();
    tick1Hz = 1'b0;
    chk("midplay_sec", secLeft, PT - 1);
    chk("midplay_window", inputEnable, 1);
    Reset_n = 1'b0;
    #1;
    check_reset("midrst");
    repeat (2) begin
      cyc();
      chk("midrst_no_timerStart", timerStart, 0);
    end
    Reset_n = 1'b1;
    repeat (3) cyc();
    chk("post_rst_idle_timerStart", timerStart, 0);
    chk("post_rst_idle_window", inputEnable, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
